// File: rtl/nmi_timer.sv
// Memory-mapped prescaled timer: compare match (one-shot or auto-reload), overflow flag,
// level interrupt, behind a one-cycle-latency valid/ready responder.
module nmi_timer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ready_o,
    output logic        irq_o
);
    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [15:0] psc_q, psc_d;
    logic [15:0] pc_q, pc_d;
    logic [31:0] cmp_q, cmp_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  stat_q, stat_d;

    logic        accept, wr_en, tick, cnt_wr;
    logic [2:0]  sel;
    logic [1:0]  hw_set, w1c;
    logic [31:0] rd_mux, cmp_m, cnt_m;
    logic        unused_addr;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    assign unused_addr = ^{mem_addr_i[31:5], mem_addr_i[1:0]};

    always_comb begin
        accept = (state_q == IDLE) && mem_valid_i;
        wr_en  = accept && (mem_wstrb_i != 4'b0000);
        sel    = mem_addr_i[4:2];
        tick   = ctrl_q[0] && (pc_q == psc_q);
        cnt_wr = wr_en && (sel == 3'd3);
        cmp_m  = merge_bytes(cmp_q, mem_wdata_i, mem_wstrb_i);
        cnt_m  = merge_bytes(cnt_q, mem_wdata_i, mem_wstrb_i);

        case (sel)
            3'd0:    rd_mux = {29'd0, ctrl_q};
            3'd1:    rd_mux = {16'd0, psc_q};
            3'd2:    rd_mux = cmp_q;
            3'd3:    rd_mux = cnt_q;
            3'd4:    rd_mux = {30'd0, stat_q};
            default: rd_mux = 32'd0;
        endcase

        state_d = accept ? ACK : IDLE;
        ready_d = accept;
        rdata_d = accept ? rd_mux : 32'd0;

        ctrl_d = ctrl_q;
        psc_d  = psc_q;
        cmp_d  = cmp_q;
        cnt_d  = cnt_q;
        hw_set = 2'b00;
        pc_d   = (ctrl_q[0] && !tick) ? pc_q + 16'd1 : 16'd0;

        // A bus write to CNT discards a coincident tick entirely.
        if (tick && !cnt_wr) begin
            if (cnt_q == cmp_q) begin
                hw_set[0] = 1'b1;
                if (ctrl_q[2]) cnt_d = 32'd0;
                else           ctrl_d[0] = 1'b0;
            end else begin
                cnt_d     = cnt_q + 32'd1;
                hw_set[1] = (cnt_q == 32'hFFFF_FFFF);
            end
        end

        w1c    = (wr_en && (sel == 3'd4)) ? mem_wdata_i[1:0] : 2'b00;
        stat_d = (stat_q & ~w1c) | hw_set;

        // Bus writes are applied last so they override the one-shot EN clear.
        if (wr_en) begin
            case (sel)
                3'd0: begin
                    if (mem_wstrb_i[0]) ctrl_d = mem_wdata_i[2:0];
                    pc_d = 16'd0;
                end
                3'd1: begin
                    psc_d = {mem_wstrb_i[1] ? mem_wdata_i[15:8] : psc_q[15:8],
                             mem_wstrb_i[0] ? mem_wdata_i[7:0]  : psc_q[7:0]};
                    pc_d  = 16'd0;
                end
                3'd2:    cmp_d = cmp_m;
                3'd3:    cnt_d = cnt_m;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
            ctrl_q  <= 3'd0;
            psc_q   <= 16'd0;
            pc_q    <= 16'd0;
            cmp_q   <= 32'd0;
            cnt_q   <= 32'd0;
            stat_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            ctrl_q  <= ctrl_d;
            psc_q   <= psc_d;
            pc_q    <= pc_d;
            cmp_q   <= cmp_d;
            cnt_q   <= cnt_d;
            stat_q  <= stat_d;
        end
    end

    assign mem_ready_o = ready_q;
    assign mem_rdata_o = rdata_q;
    assign irq_o       = ctrl_q[1] & stat_q[0];
endmodule

// File: tb/tb_nmi_timer.sv
// Self-checking bench for nmi_timer: directed table, multi-cycle corner sequences and
// random bus traffic, all compared every cycle against a register-array reference model.
module tb_nmi_timer;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready, irq;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    // Reference state: word-indexed register file 0..4, prescale phase, responder phase.
    logic [31:0] m_reg [0:4];
    logic [31:0] m_div, m_rdata;
    logic        m_ack;

    logic [31:0] rv, rdat, rad;
    logic [3:0]  rstrb;
    logic [2:0]  rsel;
    int          rk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    nmi_timer dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .mem_valid_i (mem_valid),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_wstrb_i (mem_wstrb),
        .mem_rdata_o (mem_rdata),
        .mem_ready_o (mem_ready),
        .irq_o       (irq)
    );

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] reg_mask(input int w);
        case (w)
            0:       return 32'h7;
            1:       return 32'hFFFF;
            4:       return 32'h3;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] nxt [0:4];
        logic [31:0] rd, ndiv;
        logic [1:0]  sets;
        logic        acc, wr, tick;
        int          w;
        if (rst) begin
            foreach (m_reg[i]) m_reg[i] = 32'd0;
            m_div = 32'd0; m_ack = 1'b0; m_rdata = 32'd0;
            return;
        end
        w   = int'(mem_addr[4:2]);
        acc = mem_valid && !m_ack;
        wr  = acc && (mem_wstrb != 4'd0);
        rd  = 32'd0;
        if (w < 5) rd = m_reg[w];
        foreach (nxt[i]) nxt[i] = m_reg[i];
        tick = m_reg[0][0] && (m_div == m_reg[1]);
        ndiv = (m_reg[0][0] && !tick) ? m_div + 32'd1 : 32'd0;
        sets = 2'b00;
        if (tick && !(wr && w == 3)) begin
            if (m_reg[3] == m_reg[2]) begin
                sets[0] = 1'b1;
                if (m_reg[0][2]) nxt[3] = 32'd0;
                else             nxt[0][0] = 1'b0;
            end else begin
                nxt[3] = m_reg[3] + 32'd1;
                if (m_reg[3] == 32'hFFFF_FFFF) sets[1] = 1'b1;
            end
        end
        if (wr && w == 4) begin
            nxt[4] = m_reg[4] & ~(mem_wdata & 32'h3);
        end else if (wr && w < 4) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) nxt[w][8*b +: 8] = mem_wdata[8*b +: 8];
            nxt[w] = nxt[w] & reg_mask(w);
            if (w <= 1) ndiv = 32'd0;
        end
        nxt[4] = nxt[4] | {30'd0, sets};
        foreach (m_reg[i]) m_reg[i] = nxt[i];
        m_div   = ndiv;
        m_ack   = acc;
        m_rdata = acc ? rd : 32'd0;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        if (chk_en)
            check("cycle_outputs", 64'({mem_ready, mem_rdata, irq}),
                  64'({m_ack, m_rdata, m_reg[0][1] & m_reg[4][0]}));
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] r);
        int n;
        mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
        n = 0;
        cyc();
        while (!mem_ready && n < 8) begin
            cyc();
            n++;
        end
        check("bus_ready", 64'(mem_ready), 64'd1);
        r = mem_rdata;
        mem_valid = 1'b0; mem_wstrb = 4'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_valid = 1'b0; mem_wstrb = 4'd0;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_valid = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0; mem_wstrb = 4'd0;
        cyc();
        chk_en = 1'b1;
        do_reset();
        check("rst_ready", 64'(mem_ready), 64'd0);
        check("rst_rdata", 64'(mem_rdata), 64'd0);
        check("rst_irq",   64'(irq),       64'd0);

        // Read latency with valid held through two transactions.
        mem_valid = 1'b1; mem_addr = 32'h8; mem_wstrb = 4'd0;
        cyc();
        check("lat_c2_ready", 64'(mem_ready), 64'd1);
        check("lat_c2_rdata", 64'(mem_rdata), 64'd0);
        cyc();
        check("lat_c3_ready", 64'(mem_ready), 64'd0);
        cyc();
        check("held_valid_new_txn", 64'(mem_ready), 64'd1);
        mem_valid = 1'b0;
        cyc();
        check("held_valid_release", 64'(mem_ready), 64'd0);

        tbl.push_back('{32'h00, 32'h0,         4'h0, 32'h0});
        tbl.push_back('{32'h04, 32'h0,         4'h0, 32'h0});
        tbl.push_back('{32'h0C, 32'h0,         4'h0, 32'h0});
        tbl.push_back('{32'h10, 32'h0,         4'h0, 32'h0});
        tbl.push_back('{32'h14, 32'h0,         4'h0, 32'h0});
        tbl.push_back('{32'h08, 32'hAABBCCDD,  4'h2, 32'h0});
        tbl.push_back('{32'h08, 32'h0,         4'h0, 32'h0000CC00});
        tbl.push_back('{32'h04, 32'h12345678,  4'hF, 32'h0});
        tbl.push_back('{32'h04, 32'h0,         4'h0, 32'h5678});
        tbl.push_back('{32'h04, 32'hFFFFFF9A,  4'h1, 32'h0});
        tbl.push_back('{32'h04, 32'h0,         4'h0, 32'h569A});
        tbl.push_back('{32'h00, 32'hFFFFFFFE,  4'hF, 32'h0});
        tbl.push_back('{32'h00, 32'h0,         4'h0, 32'h6});
        tbl.push_back('{32'h18, 32'hFFFFFFFF,  4'hF, 32'h0});
        tbl.push_back('{32'h18, 32'h0,         4'h0, 32'h0});
        tbl.push_back('{32'h0C, 32'h11223344,  4'hC, 32'h0});
        tbl.push_back('{32'h0C, 32'h0,         4'h0, 32'h11220000});
        tbl.push_back('{32'h00, 32'h0,         4'hF, 32'h0});
        foreach (tbl[i]) begin
            bus(tbl[i].addr, tbl[i].data, tbl[i].strb, rv);
            if (tbl[i].strb == 4'd0) check($sformatf("tbl_rd_%0d", i), 64'(rv), 64'(tbl[i].exp));
        end

        // Auto-reload: PSC=3, CMP=5 -> match 24 cycles after enable.
        do_reset();
        bus(32'h04, 32'd3, 4'hF, rv);
        bus(32'h08, 32'd5, 4'hF, rv);
        bus(32'h00, 32'h7, 4'hF, rv);
        repeat (23) cyc();
        check("ar_irq_early", 64'(irq), 64'd0);
        cyc();
        check("ar_irq_match", 64'(irq), 64'd1);
        bus(32'h10, 32'd0, 4'h0, rv); check("ar_stat", 64'(rv), 64'd1);
        bus(32'h0C, 32'd0, 4'h0, rv); check("ar_cnt_restart", 64'(rv), 64'd0);
        bus(32'h10, 32'd1, 4'h1, rv); check("ar_w1c_irq", 64'(irq), 64'd0);

        // One-shot: PSC=0, CMP=2.
        do_reset();
        bus(32'h08, 32'd2, 4'hF, rv);
        bus(32'h00, 32'h3, 4'hF, rv);
        repeat (5) cyc();
        bus(32'h00, 32'd0, 4'h0, rv); check("os_ctrl", 64'(rv), 64'h2);
        bus(32'h0C, 32'd0, 4'h0, rv); check("os_cnt", 64'(rv), 64'd2);
        bus(32'h10, 32'd0, 4'h0, rv); check("os_stat", 64'(rv), 64'd1);
        check("os_irq", 64'(irq), 64'd1);

        // Overflow wrap.
        do_reset();
        bus(32'h0C, 32'hFFFFFFFF, 4'hF, rv);
        bus(32'h08, 32'h10, 4'hF, rv);
        bus(32'h00, 32'h1, 4'hF, rv);
        bus(32'h0C, 32'd0, 4'h0, rv); check("ovf_cnt_wrap", 64'(rv), 64'd0);
        bus(32'h10, 32'd0, 4'h0, rv); check("ovf_stat", 64'(rv), 64'h2);

        // CNT write coincident with a tick (PSC=3: ticks 4,8,.. edges after enable).
        do_reset();
        bus(32'h04, 32'd3, 4'hF, rv);
        bus(32'h08, 32'h1000, 4'hF, rv);
        bus(32'h00, 32'h1, 4'hF, rv);
        repeat (3) cyc();
        bus(32'h0C, 32'h100, 4'hF, rv);
        bus(32'h0C, 32'd0, 4'h0, rv); check("cnt_wr_vs_tick", 64'(rv), 64'h100);

        // One-shot EN clear coincident with bus CTRL write.
        do_reset();
        bus(32'h08, 32'd1, 4'hF, rv);
        bus(32'h00, 32'h1, 4'hF, rv);
        bus(32'h00, 32'h5, 4'hF, rv);
        bus(32'h00, 32'd0, 4'h0, rv); check("en_clear_vs_bus", 64'(rv), 64'h5);

        // STAT W1C coincident with MATCH set, then on a quiet edge.
        do_reset();
        bus(32'h08, 32'd1, 4'hF, rv);
        bus(32'h00, 32'h7, 4'hF, rv);
        bus(32'h10, 32'h1, 4'hF, rv); check("w1c_vs_set_irq", 64'(irq), 64'd1);
        repeat (2) cyc();
        bus(32'h10, 32'h1, 4'hF, rv); check("w1c_quiet_irq", 64'(irq), 64'd0);

        // Reset during the ACK cycle of a CTRL write.
        do_reset();
        mem_valid = 1'b1; mem_addr = 32'h0; mem_wdata = 32'h7; mem_wstrb = 4'hF;
        cyc();
        check("abort_ack_seen", 64'(mem_ready), 64'd1);
        rst = 1'b1; mem_valid = 1'b0; mem_wstrb = 4'd0;
        cyc();
        check("abort_ready_low", 64'(mem_ready), 64'd0);
        rst = 1'b0;
        bus(32'h00, 32'd0, 4'h0, rv); check("abort_ctrl_zero", 64'(rv), 64'd0);

        // Reset in the same cycle the request is first sampled.
        mem_valid = 1'b1; mem_addr = 32'h0; mem_wdata = 32'h7; mem_wstrb = 4'hF; rst = 1'b1;
        cyc();
        check("rst_dom_ready", 64'(mem_ready), 64'd0);
        rst = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'd0;
        bus(32'h00, 32'd0, 4'h0, rv); check("rst_dom_ctrl", 64'(rv), 64'd0);

        for (int i = 0; i < 400; i++) begin
            rk = int'($urandom_range(0, 99));
            if (rk < 4) begin
                do_reset();
            end else if (rk < 25) begin
                repeat ($urandom_range(1, 6)) cyc();
            end else begin
                rsel  = 3'($urandom_range(0, 7));
                rstrb = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
                case (rsel)
                    3'd0:    rdat = $urandom_range(0, 7);
                    3'd1:    rdat = $urandom_range(0, 3);
                    3'd2:    rdat = $urandom_range(0, 8);
                    3'd3:    rdat = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFD : $urandom_range(0, 8);
                    default: rdat = $urandom;
                endcase
                rad = $urandom;
                rad[4:2] = rsel;
                bus(rad, rdat, rstrb, rv);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
